// File: rtl/reg_file_param_pkg.sv
// Shared constants and helpers for the parametrised register file.
package reg_file_param_pkg;

    // Smallest r with 2**r >= value; used to size select/address fields.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned DEF_WIDTH  = 64;
    localparam int unsigned DEF_DEPTH  = 32;
    localparam int unsigned DEF_ADDR_W = clog2(DEF_DEPTH);

endpackage

// File: rtl/reg_file_param_mux_nx1.sv
// Generic N-to-1 word multiplexer built as a binary tree of 2:1 stages.
module mux_nx1
    import reg_file_param_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SEL_W = clog2(N)
) (
    input  logic [N*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]   sel_i,
    output logic [WIDTH-1:0]   dout_c
);

    localparam int unsigned LEVELS = clog2(N);
    localparam int unsigned LEAVES = 1 << LEVELS;
    localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

    logic in_range;

    // Level d holds 2**d nodes; level LEVELS is the zero-padded leaf row.
    for (genvar d = 0; d <= LEVELS; d++) begin : g_lvl
        localparam int unsigned NODES = 1 << d;
        logic [WIDTH-1:0] v [NODES];

        if (d == LEVELS) begin : g_leaf
            for (genvar j = 0; j < LEAVES; j++) begin : g_word
                if (j < N) begin : g_data
                    assign v[j] = data_i[j*WIDTH +: WIDTH];
                end else begin : g_pad
                    assign v[j] = '0;
                end
            end
        end else begin : g_node
            for (genvar j = 0; j < NODES; j++) begin : g_sel
                assign v[j] = sel_i[LEVELS-1-d] ? g_lvl[d+1].v[2*j+1]
                                                : g_lvl[d+1].v[2*j];
            end
        end
    end

    // Padding leaves already read zero, but select bits above the tree also matter.
    assign in_range = {1'b0, sel_i} < N_EXT;
    assign dout_c   = in_range ? g_lvl[0].v[0] : '0;

endmodule

// File: rtl/reg_file_param.sv
// Register file: DEPTH x WIDTH storage, one write port, two registered read ports.
module reg_file_param
    import reg_file_param_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              rd_valid,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b
);

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    logic [DEPTH*WIDTH-1:0] mem_flat;
    logic                   wr_legal_c;
    logic                   byp_a_c;
    logic                   byp_b_c;
    logic [WIDTH-1:0]       mux_a_c;
    logic [WIDTH-1:0]       mux_b_c;
    logic                   rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]       rd_data_a_q, rd_data_a_d;
    logic [WIDTH-1:0]       rd_data_b_q, rd_data_b_d;

    assign wr_legal_c = wr_en
                      && ({1'b0, wr_addr} < DEPTH_EXT)
                      && !((ZERO_REG != 0) && (wr_addr == '0));

    // One register per entry; a hardwired-zero entry 0 has no storage at all.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        if ((ZERO_REG != 0) && (g == 0)) begin : g_zero
            assign mem_flat[g*WIDTH +: WIDTH] = '0;
        end else begin : g_reg
            logic [WIDTH-1:0] entry_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_q <= '0;
                end else if (wr_legal_c && (wr_addr == ADDR_W'(g))) begin
                    entry_q <= wr_data;
                end
            end

            assign mem_flat[g*WIDTH +: WIDTH] = entry_q;
        end
    end

    mux_nx1 #(
        .N     (DEPTH),
        .WIDTH (WIDTH),
        .SEL_W (ADDR_W)
    ) u_mux_a (
        .data_i (mem_flat),
        .sel_i  (rd_addr_a),
        .dout_c (mux_a_c)
    );

    mux_nx1 #(
        .N     (DEPTH),
        .WIDTH (WIDTH),
        .SEL_W (ADDR_W)
    ) u_mux_b (
        .data_i (mem_flat),
        .sel_i  (rd_addr_b),
        .dout_c (mux_b_c)
    );

    // Only a write that will actually land is forwarded.
    assign byp_a_c = (BYPASS != 0) && wr_legal_c && (wr_addr == rd_addr_a);
    assign byp_b_c = (BYPASS != 0) && wr_legal_c && (wr_addr == rd_addr_b);

    always_comb begin
        rd_valid_d  = rd_req;
        rd_data_a_d = rd_data_a_q;
        rd_data_b_d = rd_data_b_q;
        if (rd_req) begin
            rd_data_a_d = byp_a_c ? wr_data : mux_a_c;
            rd_data_b_d = byp_b_c ? wr_data : mux_b_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q  <= 1'b0;
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
        end else begin
            rd_valid_q  <= rd_valid_d;
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: two configurations driven in lockstep against a reference model.
module tb_reg_file_param;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rd_req;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;

    logic        rv   [2];
    logic [63:0] rda  [2];
    logic [63:0] rdb  [2];

    int checks = 0;
    int errors = 0;

    // Config 0: default (DEPTH 32, zero reg, bypass). Config 1: DEPTH 20, no zero reg, no bypass.
    int unsigned cdep [2] = '{32, 20};
    bit          czr  [2] = '{1'b1, 1'b0};
    bit          cbyp [2] = '{1'b1, 1'b0};

    logic [63:0] mdl [2][32];
    logic        ev  [2];
    logic [63:0] ea  [2];
    logic [63:0] eb  [2];

    reg_file_param #(.WIDTH(64), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_valid(rv[0]), .rd_data_a(rda[0]), .rd_data_b(rdb[0])
    );

    reg_file_param #(.WIDTH(64), .DEPTH(20), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_valid(rv[1]), .rd_data_a(rda[1]), .rd_data_b(rdb[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit legal_wr(input int c, input logic we, input logic [4:0] wa);
        return we && (int'(wa) < int'(cdep[c])) && !(czr[c] && wa == 5'd0);
    endfunction

    // What a read of address a returns at this edge, from the storage rules alone.
    function automatic logic [63:0] mval(input int c, input logic [4:0] a, input logic we,
                                         input logic [4:0] wa, input logic [63:0] wd);
        if (int'(a) >= int'(cdep[c])) return 64'd0;
        if (czr[c] && a == 5'd0) return 64'd0;
        if (cbyp[c] && legal_wr(c, we, wa) && wa == a) return wd;
        return mdl[c][a];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 32; i++) mdl[c][i] = 64'd0;
            ev[c] = 1'b0;
            ea[c] = 64'd0;
            eb[c] = 64'd0;
        end
    endtask

    task automatic compare_all(input string tag);
        for (int c = 0; c < 2; c++) begin
            check($sformatf("%s_valid%0d", tag, c), 64'(rv[c]), 64'(ev[c]));
            check($sformatf("%s_a%0d", tag, c), rda[c], ea[c]);
            check($sformatf("%s_b%0d", tag, c), rdb[c], eb[c]);
        end
    endtask

    // One clock: drive inputs, predict, clock, compare both configs.
    task automatic step(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                        input logic rq, input logic [4:0] ra, input logic [4:0] rb,
                        input string tag);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_req = rq; rd_addr_a = ra; rd_addr_b = rb;
        for (int c = 0; c < 2; c++) begin
            ev[c] = rq;
            if (rq) begin
                ea[c] = mval(c, ra, we, wa, wd);
                eb[c] = mval(c, rb, we, wa, wd);
            end
            if (legal_wr(c, we, wa)) mdl[c][wa] = wd;
        end
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = 5'd0; wr_data = 64'd0;
        rd_req = 1'b0; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        rq;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        ev;
        logic [63:0] a0, b0, a1, b1;
    } vec_t;

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{1'b1, 5'd7,  64'hDEADBEEF_CAFEF00D, 1'b0, 5'd0,  5'd0,  1'b0,
                    64'h0, 64'h0, 64'h0, 64'h0};
        tbl[1]  = '{1'b0, 5'd0,  64'h0,     1'b1, 5'd7,  5'd7,  1'b1,
                    64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D,
                    64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D};
        tbl[2]  = '{1'b1, 5'd0,  64'h1234,  1'b0, 5'd0,  5'd0,  1'b0,
                    64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D,
                    64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D};
        tbl[3]  = '{1'b0, 5'd0,  64'h0,     1'b1, 5'd0,  5'd7,  1'b1,
                    64'h0, 64'hDEADBEEF_CAFEF00D, 64'h1234, 64'hDEADBEEF_CAFEF00D};
        tbl[4]  = '{1'b1, 5'd3,  64'h11,    1'b0, 5'd0,  5'd0,  1'b0,
                    64'h0, 64'hDEADBEEF_CAFEF00D, 64'h1234, 64'hDEADBEEF_CAFEF00D};
        tbl[5]  = '{1'b1, 5'd3,  64'h22,    1'b1, 5'd3,  5'd3,  1'b1,
                    64'h22, 64'h22, 64'h11, 64'h11};
        tbl[6]  = '{1'b0, 5'd0,  64'h0,     1'b1, 5'd3,  5'd0,  1'b1,
                    64'h22, 64'h0, 64'h22, 64'h1234};
        tbl[7]  = '{1'b1, 5'd25, 64'hFF,    1'b1, 5'd25, 5'd19, 1'b1,
                    64'hFF, 64'h0, 64'h0, 64'h0};
        tbl[8]  = '{1'b1, 5'd19, 64'h99,    1'b1, 5'd25, 5'd19, 1'b1,
                    64'hFF, 64'h99, 64'h0, 64'h0};
        tbl[9]  = '{1'b0, 5'd0,  64'h0,     1'b1, 5'd19, 5'd25, 1'b1,
                    64'h99, 64'hFF, 64'h99, 64'h0};
        tbl[10] = '{1'b1, 5'd31, 64'h5,     1'b1, 5'd31, 5'd1,  1'b1,
                    64'h5, 64'h0, 64'h0, 64'h0};

        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("por");
        rst_n = 1'b1;

        // Directed vectors with literal expectations for both configurations.
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].rq, tbl[i].ra, tbl[i].rb,
                 $sformatf("vec%0d", i));
            check($sformatf("tbl%0d_v0", i), 64'(rv[0]), 64'(tbl[i].ev));
            check($sformatf("tbl%0d_a0", i), rda[0], tbl[i].a0);
            check($sformatf("tbl%0d_b0", i), rdb[0], tbl[i].b0);
            check($sformatf("tbl%0d_v1", i), 64'(rv[1]), 64'(tbl[i].ev));
            check($sformatf("tbl%0d_a1", i), rda[1], tbl[i].a1);
            check($sformatf("tbl%0d_b1", i), rdb[1], tbl[i].b1);
        end

        // Streamed reads followed by a hold cycle.
        step(1'b1, 5'd1, 64'hA1, 1'b0, 5'd0, 5'd0, "sw1");
        step(1'b1, 5'd2, 64'hA2, 1'b0, 5'd0, 5'd0, "sw2");
        step(1'b1, 5'd3, 64'hA3, 1'b0, 5'd0, 5'd0, "sw3");
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 5'd0, 64'd0, 1'b1, 5'(i), 5'(i), $sformatf("str%0d", i));
            check($sformatf("stream%0d_v", i), 64'(rv[0]), 64'd1);
            check($sformatf("stream%0d_a", i), rda[0], 64'hA0 + 64'(i));
        end
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd1, 5'd2, "hold");
        check("hold_v", 64'(rv[0]), 64'd0);
        check("hold_a", rda[0], 64'hA3);
        check("hold_b", rdb[0], 64'hA3);

        // Randomised traffic, including out-of-range and zero-entry addresses.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] wa, ra, rb;
            wa = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), wa, {$urandom, $urandom},
                 1'($urandom_range(0, 3) != 0), ra, rb, "rnd");
        end

        // Fill, then assert reset mid-cycle with a read in flight.
        for (int i = 1; i < 32; i++) begin
            step(1'b1, 5'(i), {32'hC0DE0000 + 32'(i), 32'(i)}, 1'b0, 5'd0, 5'd0, "fill");
        end
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 5'd9, "pre_rst");
        check("pre_rst_valid", 64'(rv[0]), 64'd1);
        #3;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        compare_all("async_rst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        compare_all("rst_rel");
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 5'd19, "post_rst");
        check("post_rst_a5", rda[0], 64'd0);
        check("post_rst_v", 64'(rv[0]), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
